// File: rtl/axil_regbank.sv
// AXI4-Lite slave register bank. The low NUM_REGS-NUM_RO registers are read/write and driven to
// the core. The top NUM_RO registers are read-only status. Supports byte strobes and SLVERR.
module axil_regbank #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned NUM_RO     = 2
) (
  input  logic                                   ACLK,
  input  logic                                   ARESETN,
  input  logic [ADDR_WIDTH-1:0]                  S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]                  S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]                S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]                  S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]                  S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [DATA_WIDTH*(NUM_REGS-NUM_RO)-1:0] reg_out,
  input  logic [DATA_WIDTH*NUM_RO-1:0]           status_in,
  output logic [NUM_REGS-NUM_RO-1:0]             wr_pulse
);

  localparam int unsigned NumRw = NUM_REGS - NUM_RO;
  localparam int unsigned IdxW  = ADDR_WIDTH - 2;
  localparam int unsigned NumB  = DATA_WIDTH / 8;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  logic [DATA_WIDTH-1:0] regs_q [NumRw];
  logic [DATA_WIDTH-1:0] regs_d [NumRw];
  logic [NumRw-1:0]      wr_pulse_q, wr_pulse_d;
  logic                  aw_held_q, aw_held_d;
  logic [IdxW-1:0]       aw_idx_q, aw_idx_d;
  logic                  w_held_q, w_held_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [NumB-1:0]       w_strb_q, w_strb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [IdxW-1:0]       ar_idx;

  // PROT and the byte offset within a word carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Gating with ARESETN keeps every READY low for the whole reset assertion.
  assign S_AXI_AWREADY = ARESETN && !aw_held_q && !bvalid_q;
  assign S_AXI_WREADY  = ARESETN && !w_held_q && !bvalid_q;
  assign S_AXI_ARREADY = ARESETN && !rvalid_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign wr_pulse      = wr_pulse_q;
  assign ar_idx        = S_AXI_ARADDR[ADDR_WIDTH-1:2];

  always_comb begin
    reg_out = '0;
    for (int unsigned i = 0; i < NumRw; i++) begin
      reg_out[DATA_WIDTH*i +: DATA_WIDTH] = regs_q[i];
    end
  end

  always_comb begin
    regs_d     = regs_q;
    wr_pulse_d = '0;
    aw_held_d  = aw_held_q;
    aw_idx_d   = aw_idx_q;
    w_held_d   = w_held_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    if (bvalid_q && S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end
    if (S_AXI_AWVALID && S_AXI_AWREADY) begin
      aw_held_d = 1'b1;
      aw_idx_d  = S_AXI_AWADDR[ADDR_WIDTH-1:2];
    end
    if (S_AXI_WVALID && S_AXI_WREADY) begin
      w_held_d = 1'b1;
      w_data_d = S_AXI_WDATA;
      w_strb_d = S_AXI_WSTRB;
    end
    if (aw_held_q && w_held_q) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = RespSlverr;
      for (int unsigned i = 0; i < NumRw; i++) begin
        if (32'(aw_idx_q) == i) begin
          bresp_d       = RespOkay;
          wr_pulse_d[i] = 1'b1;
          for (int unsigned b = 0; b < NumB; b++) begin
            if (w_strb_q[b]) regs_d[i][8*b +: 8] = w_data_q[8*b +: 8];
          end
        end
      end
    end
  end

  // Reads see regs_q, so a same-edge commit to the same register returns the old value.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
    if (S_AXI_ARVALID && S_AXI_ARREADY) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = RespSlverr;
      for (int unsigned i = 0; i < NumRw; i++) begin
        if (32'(ar_idx) == i) begin
          rdata_d = regs_q[i];
          rresp_d = RespOkay;
        end
      end
      for (int unsigned i = 0; i < NUM_RO; i++) begin
        if (32'(ar_idx) == NumRw + i) begin
          rdata_d = status_in[DATA_WIDTH*i +: DATA_WIDTH];
          rresp_d = RespOkay;
        end
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int unsigned i = 0; i < NumRw; i++) regs_q[i] <= '0;
      wr_pulse_q <= '0;
      aw_held_q  <= 1'b0;
      aw_idx_q   <= '0;
      w_held_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= 2'b00;
    end else begin
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
      aw_held_q  <= aw_held_d;
      aw_idx_q   <= aw_idx_d;
      w_held_q   <= w_held_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

endmodule

// File: tb/tb_axil_regbank.sv
// Directed self-checking bench for axil_regbank: handshakes, strobes, read-only and illegal
// accesses, back-pressure and reset abort.
module tb_axil_regbank;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [5:0]   awaddr = '0;
  logic [2:0]   awprot = '0;
  logic         awvalid = 1'b0;
  logic         awready;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         wvalid = 1'b0;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready = 1'b0;
  logic [5:0]   araddr = '0;
  logic [2:0]   arprot = '0;
  logic         arvalid = 1'b0;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready = 1'b0;
  logic [191:0] reg_out;
  logic [63:0]  status_in = '0;
  logic [5:0]   wr_pulse;

  int vectors = 0;
  int miscompares = 0;
  int pulse_cnt [6] = '{default: 0};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 6; i++) if (wr_pulse[i]) pulse_cnt[i]++;
  end

  axil_regbank #(
    .DATA_WIDTH(32), .ADDR_WIDTH(6), .NUM_REGS(8), .NUM_RO(2)
  ) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_out(reg_out), .status_in(status_in), .wr_pulse(wr_pulse)
  );

  task automatic send_aw_w(input logic [5:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
    int n = 0;
    logic a_hs, w_hs;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    while ((awvalid || wvalid) && n < 50) begin
      a_hs = awvalid && awready;
      w_hs = wvalid && wready;
      @(posedge clk); #1;
      if (a_hs) awvalid = 1'b0;
      if (w_hs) wvalid = 1'b0;
      n++;
    end
    if (awvalid || wvalid) begin
      vectors++; miscompares++;
      $display("FAIL aw_w_handshake: timed out, got no ready, required ready within 50 cycles");
      awvalid = 1'b0; wvalid = 1'b0;
    end
  endtask

  task automatic take_b(output logic [1:0] resp);
    int n = 0;
    bready = 1'b1;
    while (!bvalid && n < 50) begin @(posedge clk); #1; n++; end
    if (!bvalid) begin
      vectors++; miscompares++;
      $display("FAIL bvalid_wait: got bvalid=0, required bvalid=1 within 50 cycles");
    end
    resp = bresp;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    send_aw_w(addr, data, strb);
    take_b(resp);
  endtask

  task automatic send_ar(input logic [5:0] addr);
    int n = 0;
    araddr = addr; arvalid = 1'b1;
    while (!arready && n < 50) begin @(posedge clk); #1; n++; end
    if (!arready) begin
      vectors++; miscompares++;
      $display("FAIL ar_handshake: got arready=0, required arready=1 within 50 cycles");
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic take_r(output logic [31:0] data, output logic [1:0] resp);
    int n = 0;
    rready = 1'b1;
    while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
    if (!rvalid) begin
      vectors++; miscompares++;
      $display("FAIL rvalid_wait: got rvalid=0, required rvalid=1 within 50 cycles");
    end
    data = rdata; resp = rresp;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic axi_read(input logic [5:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    send_ar(addr);
    take_r(data, resp);
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({awready, wready, arready} !== 3'b000) begin
      miscompares++; $display("FAIL reset_ready: got %b, required 000", {awready, wready, arready});
    end
    vectors++;
    if ({bvalid, rvalid, bresp, rresp, wr_pulse} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %h, required 000", {bvalid, rvalid, bresp, rresp, wr_pulse});
    end
    vectors++;
    if ({reg_out, rdata} !== 224'h0) begin
      miscompares++; $display("FAIL reset_data: got %h, required 0", {reg_out, rdata});
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({awready, wready, arready} !== 3'b111) begin
      miscompares++;
      $display("FAIL post_reset_ready: got %b, required 111", {awready, wready, arready});
    end
  endtask

  task automatic test_basic_rw;
    logic [1:0] r;
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      axi_write(6'(4 * i), 32'(i + 1), 4'hF, r);
      vectors++;
      if (r !== 2'b00) begin miscompares++; $display("FAIL basic_bresp[%0d]: got %b, required 00", i, r); end
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(6'(4 * i), d, r);
      vectors++;
      if (d !== 32'(i + 1) || r !== 2'b00) begin
        miscompares++;
        $display("FAIL basic_read[%0d]: got %h/%b, required %h/00", i, d, r, 32'(i + 1));
      end
    end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (pulse_cnt[i] !== ((i < 4) ? 1 : 0)) begin
        miscompares++;
        $display("FAIL basic_pulse[%0d]: got %0d, required %0d", i, pulse_cnt[i], (i < 4) ? 1 : 0);
      end
    end
    vectors++;
    if (reg_out !== {32'h0, 32'h0, 32'h4, 32'h3, 32'h2, 32'h1}) begin
      miscompares++; $display("FAIL basic_reg_out: got %h", reg_out);
    end
  endtask

  task automatic test_w_first;
    logic [1:0] r;
    int n = 0;
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    while (!wready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    wvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (bvalid !== 1'b0) begin miscompares++; $display("FAIL wfirst_early_b: got 1, required 0"); end
    awaddr = 6'h04; awvalid = 1'b1;
    vectors++;
    if (awready !== 1'b1) begin miscompares++; $display("FAIL wfirst_awready: got 0, required 1"); end
    @(posedge clk); #1;
    awvalid = 1'b0;
    vectors++;
    if ({bvalid, reg_out[63:32]} !== {1'b0, 32'h2}) begin
      miscompares++;
      $display("FAIL wfirst_pre_commit: got %b/%h, required 0/00000002", bvalid, reg_out[63:32]);
    end
    @(posedge clk); #1;
    vectors++;
    if ({bvalid, wr_pulse, reg_out[63:32]} !== {1'b1, 6'b000010, 32'hDEADBEEF}) begin
      miscompares++;
      $display("FAIL wfirst_commit: got %b/%b/%h, required 1/000010/deadbeef",
               bvalid, wr_pulse, reg_out[63:32]);
    end
    take_b(r);
    vectors++;
    if (r !== 2'b00) begin miscompares++; $display("FAIL wfirst_bresp: got %b, required 00", r); end
  endtask

  task automatic test_strobe;
    logic [1:0] r;
    logic [31:0] d;
    int p2;
    p2 = pulse_cnt[2];
    axi_write(6'h08, 32'h11223344, 4'hF, r);
    axi_write(6'h08, 32'hAABBCCDD, 4'h5, r);
    vectors++;
    if (reg_out[95:64] !== 32'h11BB33DD) begin
      miscompares++; $display("FAIL strobe_reg_out: got %h, required 11bb33dd", reg_out[95:64]);
    end
    axi_read(6'h08, d, r);
    vectors++;
    if (d !== 32'h11BB33DD) begin
      miscompares++; $display("FAIL strobe_read: got %h, required 11bb33dd", d);
    end
    axi_write(6'h08, 32'hFFFFFFFF, 4'h0, r);
    vectors++;
    if (r !== 2'b00 || reg_out[95:64] !== 32'h11BB33DD) begin
      miscompares++;
      $display("FAIL strobe_zero: got %b/%h, required 00/11bb33dd", r, reg_out[95:64]);
    end
    vectors++;
    if (pulse_cnt[2] - p2 !== 3) begin
      miscompares++; $display("FAIL strobe_pulses: got %0d, required 3", pulse_cnt[2] - p2);
    end
  endtask

  task automatic test_ro_err;
    logic [1:0] r;
    logic [31:0] d;
    int psum;
    psum = pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3] + pulse_cnt[4] + pulse_cnt[5];
    status_in = {32'h12345678, 32'hCAFEF00D};
    axi_read(6'h18, d, r);
    vectors++;
    if (d !== 32'hCAFEF00D || r !== 2'b00) begin
      miscompares++; $display("FAIL ro_read6: got %h/%b, required cafef00d/00", d, r);
    end
    axi_read(6'h1C, d, r);
    vectors++;
    if (d !== 32'h12345678 || r !== 2'b00) begin
      miscompares++; $display("FAIL ro_read7: got %h/%b, required 12345678/00", d, r);
    end
    axi_read(6'h07, d, r);
    vectors++;
    if (d !== 32'hDEADBEEF || r !== 2'b00) begin
      miscompares++; $display("FAIL low_bits_ignored: got %h/%b, required deadbeef/00", d, r);
    end
    axi_write(6'h18, 32'h0BADF00D, 4'hF, r);
    vectors++;
    if (r !== 2'b10) begin miscompares++; $display("FAIL ro_write_bresp: got %b, required 10", r); end
    axi_write(6'h3C, 32'h0BADF00D, 4'hF, r);
    vectors++;
    if (r !== 2'b10) begin miscompares++; $display("FAIL oob_write_bresp: got %b, required 10", r); end
    vectors++;
    if (reg_out !== {32'h0, 32'h0, 32'h4, 32'h11BB33DD, 32'hDEADBEEF, 32'h1}) begin
      miscompares++; $display("FAIL err_no_change: got %h", reg_out);
    end
    vectors++;
    if (pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3] + pulse_cnt[4] + pulse_cnt[5]
        !== psum) begin
      miscompares++; $display("FAIL err_no_pulse: pulse seen on rejected write");
    end
    axi_read(6'h20, d, r);
    vectors++;
    if (d !== 32'h0 || r !== 2'b10) begin
      miscompares++; $display("FAIL oob_read: got %h/%b, required 00000000/10", d, r);
    end
  endtask

  task automatic test_backpressure;
    logic [1:0] r;
    logic [31:0] d;
    int n = 0;
    send_aw_w(6'h0C, 32'h0F0F0F0F, 4'hF);
    while (!bvalid && n < 20) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if ({bvalid, bresp, awready, wready} !== 5'b10000) begin
        miscompares++;
        $display("FAIL bp_write[%0d]: got %b, required 10000", i, {bvalid, bresp, awready, wready});
      end
      @(posedge clk); #1;
    end
    take_b(r);
    vectors++;
    if ({bvalid, awready, wready} !== 3'b011) begin
      miscompares++; $display("FAIL bp_write_done: got %b, required 011", {bvalid, awready, wready});
    end
    send_ar(6'h0C);
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if ({rvalid, rdata, rresp, arready} !== {1'b1, 32'h0F0F0F0F, 2'b00, 1'b0}) begin
        miscompares++;
        $display("FAIL bp_read[%0d]: got %b/%h/%b/%b, required 1/0f0f0f0f/00/0",
                 i, rvalid, rdata, rresp, arready);
      end
      @(posedge clk); #1;
    end
    take_r(d, r);
    vectors++;
    if ({rvalid, arready} !== 2'b01) begin
      miscompares++; $display("FAIL bp_read_done: got %b, required 01", {rvalid, arready});
    end
  endtask

  task automatic test_reset_abort;
    logic [1:0] r;
    int n = 0;
    int p1, p2;
    awaddr = 6'h04; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({reg_out, rdata, wr_pulse, bvalid, rvalid, bresp, rresp} !== 236'h0) begin
      miscompares++; $display("FAIL abort_reset_outputs: outputs not all zero");
    end
    vectors++;
    if ({awready, wready, arready} !== 3'b000) begin
      miscompares++; $display("FAIL abort_ready: got %b, required 000", {awready, wready, arready});
    end
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    p1 = pulse_cnt[1]; p2 = pulse_cnt[2];
    wdata = 32'h77777777; wstrb = 4'hF; wvalid = 1'b1;
    while (!wready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    wvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({bvalid, reg_out} !== 193'h0) begin
      miscompares++; $display("FAIL abort_stale_commit: got bvalid=%b reg_out=%h, required 0", bvalid, reg_out);
    end
    awaddr = 6'h08; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    awvalid = 1'b0;
    take_b(r);
    vectors++;
    if (r !== 2'b00 || reg_out[95:32] !== {32'h77777777, 32'h0}) begin
      miscompares++;
      $display("FAIL abort_after_write: got %b/%h, required 00/7777777700000000", r, reg_out[95:32]);
    end
    vectors++;
    if (pulse_cnt[1] - p1 !== 0 || pulse_cnt[2] - p2 !== 1) begin
      miscompares++;
      $display("FAIL abort_pulses: got %0d/%0d, required 0/1", pulse_cnt[1] - p1, pulse_cnt[2] - p2);
    end
  endtask

  initial begin
    test_reset();
    test_basic_rw();
    test_w_first();
    test_strobe();
    test_ro_err();
    test_backpressure();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
